// File: rtl/drca_op_sequencer_if.sv
// Operand, DRCA and result signals of the DRCA op sequencer.
// The sequencer takes the slave view; the operand issuer, DRCA and result sink take the master view.
interface drca_op_sequencer_if #(
    parameter int N     = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             in_cin;
    logic             drca_en;
    logic [N-1:0]     drca_a;
    logic [N-1:0]     drca_b;
    logic             drca_cin;
    logic [N-1:0]     drca_s;
    logic [N-1:0]     drca_p;
    logic             drca_cout;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_sum;
    logic             out_cout;
    logic             out_slow;
    logic [CNT_W-1:0] slow_cnt;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, drca_s, drca_p, drca_cout, out_ready,
        output in_ready, drca_en, drca_a, drca_b, drca_cin,
               out_valid, out_sum, out_cout, out_slow, slow_cnt
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, drca_s, drca_p, drca_cout, out_ready,
        input  in_ready, drca_en, drca_a, drca_b, drca_cin,
               out_valid, out_sum, out_cout, out_slow, slow_cnt
    );
endinterface

// File: rtl/drca_op_sequencer.sv
// Issue/collect controller for the DRCA adder: one operation in flight, capture time
// chosen from the longest propagate run (short runs settle in one cycle, long runs in two).
module drca_op_sequencer #(
    parameter int N      = 8,
    parameter int THRESH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    drca_op_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, EVAL1, EVAL2, DONE} state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   run_slow;
    logic   capture;

    function automatic int longest_run(input logic [N-1:0] p);
        int best;
        int cur;
        best = 0;
        cur  = 0;
        for (int i = 0; i < N; i++) begin
            if (p[i]) begin
                cur = cur + 1;
                if (cur > best) best = cur;
            end else begin
                cur = 0;
            end
        end
        return best;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Operands are registered before EVAL1, so P is stable for the whole cycle.
    assign run_slow = (longest_run(bus.drca_p) >= THRESH);
    assign accept   = bus.in_valid & bus.in_ready;
    assign capture  = ((state == EVAL1) && !run_slow) || (state == EVAL2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.drca_en   = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = EVAL1;
            end
            EVAL1: begin
                bus.drca_en = 1'b1;
                state_nxt   = run_slow ? EVAL2 : DONE;
            end
            EVAL2: begin
                bus.drca_en = 1'b1;
                state_nxt   = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                // Releasing the result frees the slot, so a new operand set can enter now.
                bus.in_ready  = bus.out_ready;
                if (bus.out_ready) state_nxt = bus.in_valid ? EVAL1 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.drca_a   <= '0;
            bus.drca_b   <= '0;
            bus.drca_cin <= 1'b0;
            bus.out_sum  <= '0;
            bus.out_cout <= 1'b0;
            bus.out_slow <= 1'b0;
            bus.slow_cnt <= '0;
        end else begin
            if (accept) begin
                bus.drca_a   <= bus.in_a;
                bus.drca_b   <= bus.in_b;
                bus.drca_cin <= bus.in_cin;
            end
            if (capture) begin
                bus.out_sum  <= bus.drca_s;
                bus.out_cout <= bus.drca_cout;
                bus.out_slow <= (state == EVAL2);
            end
            if (state == EVAL2) bus.slow_cnt <= sat_inc(bus.slow_cnt);
        end
    end
endmodule

// File: tb/tb_drca_op_sequencer.sv
// Bench for drca_op_sequencer: timeline model of accept/latency/handshake checked every cycle,
// plus directed operations with hand-computed results; a CNT_W=2 copy checks saturation.
module tb_drca_op_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    drca_op_sequencer_if #(.N(8), .CNT_W(16)) b1 ();
    drca_op_sequencer_if #(.N(8), .CNT_W(2))  b2 ();

    drca_op_sequencer #(.N(8), .THRESH(4), .CNT_W(16)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(b1));
    drca_op_sequencer #(.N(8), .THRESH(4), .CNT_W(2))  u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    always #5 clk = ~clk;

    // Behavioural DRCA attached to each sequencer
    assign b1.drca_p = b1.drca_a ^ b1.drca_b;
    assign {b1.drca_cout, b1.drca_s} = {1'b0, b1.drca_a} + {1'b0, b1.drca_b} + {8'd0, b1.drca_cin};
    assign b2.drca_p = b2.drca_a ^ b2.drca_b;
    assign {b2.drca_cout, b2.drca_s} = {1'b0, b2.drca_a} + {1'b0, b2.drca_b} + {8'd0, b2.drca_cin};

    assign b2.in_valid  = b1.in_valid;
    assign b2.in_a      = b1.in_a;
    assign b2.in_b      = b1.in_b;
    assign b2.in_cin    = b1.in_cin;
    assign b2.out_ready = b1.out_ready;

    int nchk = 0;
    int npass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic int run_len(input logic [7:0] p);
        int best = 0;
        int cur = 0;
        for (int i = 0; i < 8; i++) begin
            if (p[i]) begin
                cur++;
                if (cur > best) best = cur;
            end else cur = 0;
        end
        return best;
    endfunction

    // Model: an operation is in flight from accept until its result is handshaken; its result
    // becomes visible 2 (fast) or 3 (slow) clocks after the accept cycle.
    int         cyc = 0;
    bit         m_infl = 0;
    int         m_vcyc = 0;
    logic [7:0] m_a = 0, m_b = 0;
    logic       m_cin = 0;
    logic [7:0] p_sum = 0, m_sum = 0;
    logic       p_cout = 0, p_slow = 0, m_cout = 0, m_slow = 0;
    int         m_cnt = 0;

    initial begin
        forever begin
            bit rv, hs, acc, e_ready;
            @(negedge clk);
            if (!rst_n) begin
                m_infl = 0; m_cnt = 0; m_sum = 0; m_cout = 0; m_slow = 0;
            end
            rv      = m_infl && (cyc >= m_vcyc);
            e_ready = !m_infl || (rv && b1.out_ready);
            check("in_ready",  {31'd0, b1.in_ready},  {31'd0, e_ready});
            check("out_valid", {31'd0, b1.out_valid}, {31'd0, rv});
            check("drca_en",   {31'd0, b1.drca_en},   {31'd0, m_infl && !rv});
            check("slow_cnt",  {16'd0, b1.slow_cnt},  m_cnt);
            check("slow_cnt2", {30'd0, b2.slow_cnt},  (m_cnt > 3) ? 3 : m_cnt);
            if (m_infl) begin
                check("drca_ops", {15'd0, b1.drca_cin, b1.drca_a, b1.drca_b}, {15'd0, m_cin, m_a, m_b});
            end
            if (rv) begin
                check("out_res", {22'd0, b1.out_slow, b1.out_cout, b1.out_sum},
                                 {22'd0, m_slow, m_cout, m_sum});
            end
            if (rst_n) begin
                hs  = rv && b1.out_ready;
                acc = b1.in_valid && e_ready;
                if (hs) m_infl = 0;
                cyc++;
                if (acc) begin
                    m_infl = 1;
                    m_a = b1.in_a; m_b = b1.in_b; m_cin = b1.in_cin;
                    {p_cout, p_sum} = {1'b0, m_a} + {1'b0, m_b} + {8'd0, m_cin};
                    p_slow = (run_len(m_a ^ m_b) >= 4);
                    m_vcyc = cyc + (p_slow ? 2 : 1);
                end
                if (m_infl && cyc == m_vcyc) begin
                    m_sum = p_sum; m_cout = p_cout; m_slow = p_slow;
                    if (p_slow && m_cnt < 65535) m_cnt++;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic cin);
        bit rdy;
        bit ok = 0;
        b1.in_valid = 1'b1; b1.in_a = a; b1.in_b = b; b1.in_cin = cin;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            rdy = b1.in_ready;
            @(posedge clk); #1;
            if (rdy) begin ok = 1; break; end
        end
        b1.in_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    // Counts negedges after the accept until out_valid; returns at that negedge.
    task automatic wait_lat(output int lat);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (b1.out_valid) begin lat = k; break; end
        end
    endtask

    task automatic release_result();
        @(posedge clk); #1 b1.out_ready = 1'b1;
        @(posedge clk); #1 b1.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic [7:0] rs [2];
        logic       rl [2];
        int         nres;
        int         idx;
        bit         rdy, b2b;
        logic [1:0] exp6 [4];

        b1.in_valid = 0; b1.in_a = 0; b1.in_b = 0; b1.in_cin = 0; b1.out_ready = 0;
        #1 rst_n = 1'b0;
        #3;
        check("rst_in_ready",  {31'd0, b1.in_ready},  1);
        check("rst_out_valid", {31'd0, b1.out_valid}, 0);
        check("rst_drca_en",   {31'd0, b1.drca_en},   0);
        check("rst_regs",      {7'd0, b1.drca_a, b1.drca_b, b1.out_sum, b1.drca_cin}, 0);
        check("rst_slow_cnt",  {16'd0, b1.slow_cnt},  0);
        @(posedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: P=0x0E, L=3 -> fast
        issue(8'h0F, 8'h01, 1'b0);
        wait_lat(lat);
        check("t1_lat", lat, 2);
        check("t1_res", {22'd0, b1.out_slow, b1.out_cout, b1.out_sum}, {22'd0, 1'b0, 1'b0, 8'h10});
        release_result();

        // 2: P=0xFE, L=7 -> slow
        issue(8'hFF, 8'h01, 1'b0);
        wait_lat(lat);
        check("t2_lat", lat, 3);
        check("t2_res", {22'd0, b1.out_slow, b1.out_cout, b1.out_sum}, {22'd0, 1'b1, 1'b1, 8'h00});
        check("t2_cnt", {16'd0, b1.slow_cnt}, 1);

        // 3: result held while downstream stalls
        for (int i = 0; i < 5; i++) begin
            check("t3_hold", {22'd0, b1.out_valid, b1.in_ready, b1.out_sum}, {22'd0, 1'b1, 1'b0, 8'h00});
            @(negedge clk);
        end
        @(posedge clk); #1 b1.out_ready = 1'b1;
        #1 check("t3_ready", {31'd0, b1.in_ready}, 1);
        @(posedge clk); #1 b1.out_ready = 1'b0;

        // 4: back-to-back 0x01+0x02 then 0xAA+0x55
        va[0] = 8'h01; vb[0] = 8'h02; va[1] = 8'hAA; vb[1] = 8'h55;
        idx = 0; nres = 0; b2b = 0;
        b1.in_valid = 1; b1.in_a = va[0]; b1.in_b = vb[0]; b1.in_cin = 0; b1.out_ready = 1;
        for (int k = 0; k < 30 && nres < 2; k++) begin
            @(negedge clk);
            rdy = b1.in_ready;
            if (b1.out_valid) begin
                rs[nres] = b1.out_sum; rl[nres] = b1.out_slow; nres++;
                if (rdy && b1.in_valid) b2b = 1;
            end
            @(posedge clk); #1;
            if (rdy && b1.in_valid) begin
                idx++;
                if (idx < 2) begin b1.in_a = va[idx]; b1.in_b = vb[idx]; end
                else b1.in_valid = 0;
            end
        end
        b1.in_valid = 0; b1.out_ready = 0;
        check("t4_nres", nres, 2);
        check("t4_b2b", {31'd0, b2b}, 1);
        check("t4_res0", {23'd0, rl[0], rs[0]}, {23'd0, 1'b0, 8'h03});
        check("t4_res1", {23'd0, rl[1], rs[1]}, {23'd0, 1'b1, 8'hFF});
        check("t4_cnt", {16'd0, b1.slow_cnt}, 2);

        // 5: reset during EVAL2
        issue(8'hFF, 8'h01, 1'b0);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("t5_out_valid", {31'd0, b1.out_valid}, 0);
        check("t5_drca_en",   {31'd0, b1.drca_en},   0);
        check("t5_slow_cnt",  {16'd0, b1.slow_cnt},  0);
        check("t5_slow_cnt2", {30'd0, b2.slow_cnt},  0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        check("t5_ready_after", {30'd0, b1.in_ready, b1.out_valid}, {30'd0, 1'b1, 1'b0});
        @(posedge clk); #1;

        // 6: saturating 2-bit counter; includes L exactly THRESH
        va[0] = 8'hF0; vb[0] = 8'h00;
        va[1] = 8'h0F; vb[1] = 8'h00;
        va[2] = 8'hFF; vb[2] = 8'h00;
        va[3] = 8'h55; vb[3] = 8'hAA;
        exp6[0] = 2'd1; exp6[1] = 2'd2; exp6[2] = 2'd3; exp6[3] = 2'd3;
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i], 1'b0);
            wait_lat(lat);
            check("t6_lat", lat, 3);
            check("t6_cnt2", {30'd0, b2.slow_cnt}, {30'd0, exp6[i]});
            release_result();
        end
        check("t6_cnt", {16'd0, b1.slow_cnt}, 4);

        // Cin does not extend a run; P=0 gives L=0
        issue(8'h07, 8'h00, 1'b1);
        wait_lat(lat);
        check("cin_lat", lat, 2);
        check("cin_res", {22'd0, b1.out_slow, b1.out_cout, b1.out_sum}, {22'd0, 1'b0, 1'b0, 8'h08});
        release_result();
        issue(8'h00, 8'h00, 1'b1);
        wait_lat(lat);
        check("p0_lat", lat, 2);
        check("p0_res", {22'd0, b1.out_slow, b1.out_cout, b1.out_sum}, {22'd0, 1'b0, 1'b0, 8'h01});
        release_result();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
